// File: rtl/lbm_sweep_scheduler_pkg.sv
// Shared types and constants for the LBM timestep sequencer and the
// collider/streamer datapaths that sit beside it.
package lbm_pkg;

  // Sweep phase, also driven out as phase_out.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    COLLIDE = 2'd2,
    STREAM  = 2'd3
  } phase_t;

  // D2Q9 direction indices within one BRAM word (9 x 8-bit distributions).
  localparam int N_DIR  = 9;
  localparam int DIR_C  = 0;
  localparam int DIR_E  = 1;
  localparam int DIR_N  = 2;
  localparam int DIR_W  = 3;
  localparam int DIR_S  = 4;
  localparam int DIR_NE = 5;
  localparam int DIR_NW = 6;
  localparam int DIR_SW = 7;
  localparam int DIR_SE = 8;
  localparam int DIST_W = 8;
  localparam int WORD_W = N_DIR * DIST_W;

endpackage

// File: rtl/lbm_sweep_scheduler_if.sv
// Control/BRAM-side signal bundle of the sweep scheduler.
// master: the scheduler itself; slave: LBM control + BRAM/datapath side.
interface lbm_sweep_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic              start_in;
  logic              init_in;
  logic              stall_in;
  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic              init_wr_out;
  logic              collide_valid_out;
  logic              stream_valid_out;
  logic [1:0]        phase_out;
  logic              busy_out;
  logic              step_done_out;
  logic [15:0]       step_count_out;

  modport master (
    input  start_in, init_in, stall_in,
    output rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, init_wr_out,
           collide_valid_out, stream_valid_out, phase_out, busy_out,
           step_done_out, step_count_out
  );

  modport slave (
    output start_in, init_in, stall_in,
    input  rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, init_wr_out,
           collide_valid_out, stream_valid_out, phase_out, busy_out,
           step_done_out, step_count_out
  );
endinterface

// File: rtl/lbm_sweep_scheduler_token_delay.sv
// Shift register of issue tokens {collide_vld, stream_vld, addr}.
// Stage i holds a token of age i+1. The read tap exposes only the two
// valid bits (they are the registered data-valid strobes); the mid and
// full-depth taps carry whole tokens for the per-phase write-back mux.
module lbm_token_delay #(
  parameter int W       = 4,
  parameter int DEPTH   = 2,
  parameter int RD_TAP  = 1,
  parameter int MID_TAP = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] tok_i,
  output logic [1:0]   rd_vld_o,
  output logic [W-1:0] mid_o,
  output logic [W-1:0] out_o
);

  logic [W-1:0] tok_q [DEPTH];

  // Advance tokens one stage per cycle; clr_i drops everything at a phase change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) tok_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) tok_q[i] <= '0;
    end else begin
      tok_q[0] <= tok_i;
      for (int i = 1; i < DEPTH; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  assign rd_vld_o = tok_q[RD_TAP-1][W-1 -: 2];
  assign mid_o    = tok_q[MID_TAP-1];
  assign out_o    = tok_q[DEPTH-1];

endmodule

// File: rtl/lbm_sweep_scheduler.sv
// Sequences one LBM timestep: optional SETUP sweep, then COLLIDE and
// STREAM sweeps over the distribution BRAM, with read issue, data-valid
// strobes and delayed write-back addresses.
module lbm_sweep_scheduler
  import lbm_pkg::*;
#(
  parameter int BRAM_DEPTH      = 31570,
  parameter int READ_LATENCY    = 2,
  parameter int COLLIDE_LATENCY = 4,
  parameter int STREAM_LATENCY  = 1,
  parameter int ADDR_W          = $clog2(BRAM_DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  lbm_sweep_scheduler_if.master bus
);

  localparam int CL_D  = READ_LATENCY + COLLIDE_LATENCY;
  localparam int SL_D  = READ_LATENCY + STREAM_LATENCY;
  localparam int MAX_D = (CL_D > SL_D) ? CL_D : SL_D;
  localparam int MID_D = (CL_D > SL_D) ? SL_D : CL_D;
  localparam int TOK_W = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_DEPTH - 1);

  phase_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              issued_q, issued_d;
  logic              done_q, done_d;
  logic [15:0]       step_cnt_q, step_cnt_d;

  logic              setup_wr, rd_issue, flush;
  logic              wr_vld, last_wr;
  logic [TOK_W-1:0]  tok_in, tok_mid, tok_out, wr_tok;
  logic [1:0]        rd_vld;

  lbm_token_delay #(
    .W       (TOK_W),
    .DEPTH   (MAX_D),
    .RD_TAP  (READ_LATENCY),
    .MID_TAP (MID_D)
  ) u_delay (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .clr_i    (flush),
    .tok_i    (tok_in),
    .rd_vld_o (rd_vld),
    .mid_o    (tok_mid),
    .out_o    (tok_out)
  );

  // Issue decode and write-back tap selection for the active phase.
  always_comb begin
    setup_wr = (state_q == SETUP);
    rd_issue = ((state_q == COLLIDE) || (state_q == STREAM)) &&
               !issued_q && !bus.stall_in;
    tok_in   = {rd_issue && (state_q == COLLIDE),
                rd_issue && (state_q == STREAM),
                rd_issue ? cnt_q : {ADDR_W{1'b0}}};
    if (state_q == COLLIDE) wr_tok = (CL_D == MAX_D) ? tok_out : tok_mid;
    else                    wr_tok = (SL_D == MAX_D) ? tok_out : tok_mid;
    wr_vld   = wr_tok[TOK_W-1] | wr_tok[TOK_W-2];
    // Writes retire in issue order, so the last address marks the drained line.
    last_wr  = wr_vld && (wr_tok[ADDR_W-1:0] == LAST_ADDR);
  end

  // Phase sequencing, address counter and step bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    done_d     = 1'b0;
    step_cnt_d = step_cnt_q;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d  = bus.init_in ? SETUP : COLLIDE;
          cnt_d    = '0;
          issued_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = COLLIDE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      COLLIDE, STREAM: begin
        if (rd_issue) begin
          if (cnt_q == LAST_ADDR) begin
            issued_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        if (last_wr) begin
          issued_d = 1'b0;
          cnt_d    = '0;
          flush    = 1'b1;
          if (state_q == COLLIDE) begin
            state_d = STREAM;
          end else begin
            state_d    = IDLE;
            done_d     = 1'b1;
            step_cnt_d = step_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset discards the sweep in progress.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      issued_q   <= 1'b0;
      done_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign bus.rd_en_out         = rd_issue;
  assign bus.rd_addr_out       = rd_issue ? cnt_q : '0;
  assign bus.wr_en_out         = setup_wr | wr_vld;
  assign bus.wr_addr_out       = setup_wr ? cnt_q :
                                 (wr_vld ? wr_tok[ADDR_W-1:0] : '0);
  assign bus.init_wr_out       = setup_wr;
  assign bus.collide_valid_out = rd_vld[1];
  assign bus.stream_valid_out  = rd_vld[0];
  assign bus.phase_out         = state_q;
  assign bus.busy_out          = (state_q != IDLE);
  assign bus.step_done_out     = done_q;
  assign bus.step_count_out    = step_cnt_q;

endmodule
